// File: rtl/vec_exec_unit.sv
// Strip-mined vector execution unit: runs one VADD/VMUL/VMACC/VDOT op per handshake
// over ceil(vl/NLANES) beats against an external vector register file.
module vec_exec_unit #(
    parameter int VLEN   = 32,
    parameter int NLANES = 16,
    parameter int SEW    = 32,
    parameter int BW     = ((VLEN / NLANES) > 1) ? $clog2(VLEN / NLANES) : 1,
    parameter int VLW    = $clog2(VLEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [5:0]             in_funct6,
    input  logic [4:0]             in_vd,
    input  logic [4:0]             in_vs1,
    input  logic [4:0]             in_vs2,
    input  logic [VLW-1:0]         in_vl,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    output logic [4:0]             rf_raddr3,
    output logic [BW-1:0]          rf_rbeat,
    input  logic [NLANES*SEW-1:0]  rf_rdata1,
    input  logic [NLANES*SEW-1:0]  rf_rdata2,
    input  logic [NLANES*SEW-1:0]  rf_rdata3,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [BW-1:0]          rf_wbeat,
    output logic [NLANES*SEW-1:0]  rf_wdata,
    output logic [NLANES-1:0]      rf_wmask,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int IW = VLW + 1;

    localparam logic [5:0] F_VADD  = 6'b000000;
    localparam logic [5:0] F_VMUL  = 6'b100101;
    localparam logic [5:0] F_VMACC = 6'b101101;
    localparam logic [5:0] F_VDOT  = 6'b111001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    state_t           state_r;
    logic [5:0]       funct_r;
    logic [4:0]       vd_r;
    logic [4:0]       vs1_r;
    logic [4:0]       vs2_r;
    logic [VLW-1:0]   vl_r;
    logic [BW-1:0]    beat_r;
    logic [SEW-1:0]   acc_r;
    logic             ready_r;

    logic [VLW-1:0]         vl_in_s;
    logic                   legal_s;
    logic                   is_dot_s;
    logic                   last_s;
    logic [IW-1:0]          next_base_s;
    logic [NLANES-1:0]      mask_s;
    logic [NLANES*SEW-1:0]  wdata_s;
    logic [SEW-1:0]         dot_term_s [NLANES];
    logic [SEW-1:0]         dot_sum_s;

    assign in_ready  = ready_r;
    assign busy      = ~ready_r;
    assign rf_raddr1 = vs1_r;
    assign rf_raddr2 = vs2_r;
    assign rf_raddr3 = vd_r;
    assign rf_rbeat  = beat_r;

    assign vl_in_s     = (in_vl > VLW'(VLEN)) ? VLW'(VLEN) : in_vl;
    assign is_dot_s    = (funct_r == F_VDOT);
    assign next_base_s = (IW'(beat_r) + IW'(1)) * IW'(NLANES);
    assign last_s      = (next_base_s >= {1'b0, vl_r});

    // Decode which funct6 encodings this unit implements.
    always_comb begin
        case (in_funct6)
            F_VADD, F_VMUL, F_VMACC, F_VDOT: legal_s = 1'b1;
            default:                         legal_s = 1'b0;
        endcase
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        logic [SEW-1:0] a_s;
        logic [SEW-1:0] b_s;
        logic [SEW-1:0] c_s;
        logic [SEW-1:0] prod_s;
        logic [SEW-1:0] res_s;
        logic [IW-1:0]  idx_s;

        assign a_s    = rf_rdata1[k*SEW +: SEW];
        assign b_s    = rf_rdata2[k*SEW +: SEW];
        assign c_s    = rf_rdata3[k*SEW +: SEW];
        assign prod_s = a_s * b_s;
        assign idx_s  = IW'(beat_r) * IW'(NLANES) + IW'(k);
        assign mask_s[k] = (idx_s < {1'b0, vl_r});

        // Per-lane element result for the elementwise ops.
        always_comb begin
            case (funct_r)
                F_VADD:  res_s = a_s + b_s;
                F_VMACC: res_s = c_s + prod_s;
                default: res_s = prod_s;
            endcase
        end

        assign wdata_s[k*SEW +: SEW] = res_s;
        assign dot_term_s[k]         = mask_s[k] ? prod_s : {SEW{1'b0}};
    end

    // Horizontal sum of the active-lane products for the dot product.
    always_comb begin
        dot_sum_s = {SEW{1'b0}};
        for (int k = 0; k < NLANES; k++) begin
            dot_sum_s = dot_sum_s + dot_term_s[k];
        end
    end

    // Control FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wbeat <= {BW{1'b0}};
            rf_wdata <= {(NLANES*SEW){1'b0}};
            rf_wmask <= {NLANES{1'b0}};
            funct_r  <= 6'd0;
            vd_r     <= 5'd0;
            vs1_r    <= 5'd0;
            vs2_r    <= 5'd0;
            vl_r     <= {VLW{1'b0}};
            beat_r   <= {BW{1'b0}};
            acc_r    <= {SEW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rf_we    <= 1'b0;
                    rf_wmask <= {NLANES{1'b0}};
                    done     <= 1'b0;
                    err      <= 1'b0;
                    if (in_valid && ready_r) begin
                        funct_r <= in_funct6;
                        vd_r    <= in_vd;
                        vs1_r   <= in_vs1;
                        vs2_r   <= in_vs2;
                        vl_r    <= vl_in_s;
                        beat_r  <= {BW{1'b0}};
                        acc_r   <= {SEW{1'b0}};
                        ready_r <= 1'b0;
                        if (!legal_s) begin
                            state_r <= ST_FIN;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else if (vl_in_s == {VLW{1'b0}}) begin
                            state_r <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (is_dot_s) begin
                        acc_r    <= acc_r + dot_sum_s;
                        rf_we    <= 1'b0;
                        rf_wmask <= {NLANES{1'b0}};
                    end else begin
                        rf_we    <= 1'b1;
                        rf_waddr <= vd_r;
                        rf_wbeat <= beat_r;
                        rf_wdata <= wdata_s;
                        rf_wmask <= mask_s;
                    end
                    if (last_s) begin
                        state_r <= is_dot_s ? ST_REDUCE : ST_FIN;
                        done    <= ~is_dot_s;
                    end else begin
                        beat_r  <= beat_r + BW'(1);
                    end
                end
                ST_REDUCE: begin
                    // Reduction result lands in lane 0 of beat 0; other lanes untouched.
                    rf_we    <= 1'b1;
                    rf_waddr <= vd_r;
                    rf_wbeat <= {BW{1'b0}};
                    rf_wdata <= (NLANES*SEW)'(acc_r);
                    rf_wmask <= NLANES'(1'b1);
                    done     <= 1'b1;
                    state_r  <= ST_FIN;
                end
                ST_FIN: begin
                    rf_we    <= 1'b0;
                    rf_wmask <= {NLANES{1'b0}};
                    done     <= 1'b0;
                    err      <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    rf_we    <= 1'b0;
                    rf_wmask <= {NLANES{1'b0}};
                    done     <= 1'b0;
                    err      <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit: table-driven directed ops, corner sequences
// and randomized ops checked against an element-level reference model.
module tb_vec_exec_unit;

    localparam int VLEN   = 32;
    localparam int NLANES = 16;
    localparam int SEW    = 32;
    localparam int BW     = 1;
    localparam int VLW    = 6;

    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_MUL  = 6'b100101;
    localparam logic [5:0] F_MACC = 6'b101101;
    localparam logic [5:0] F_DOT  = 6'b111001;
    localparam logic [5:0] F_BAD  = 6'b010101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            in_funct6;
    logic [4:0]            in_vd, in_vs1, in_vs2;
    logic [VLW-1:0]        in_vl;
    logic [4:0]            rf_raddr1, rf_raddr2, rf_raddr3;
    logic [BW-1:0]         rf_rbeat;
    logic [NLANES*SEW-1:0] rf_rdata1, rf_rdata2, rf_rdata3;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [BW-1:0]         rf_wbeat;
    logic [NLANES*SEW-1:0] rf_wdata;
    logic [NLANES-1:0]     rf_wmask;
    logic                  busy, done, err;

    vec_exec_unit #(.VLEN(VLEN), .NLANES(NLANES), .SEW(SEW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct6(in_funct6), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vl(in_vl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3), .rf_rbeat(rf_rbeat),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wbeat(rf_wbeat), .rf_wdata(rf_wdata),
        .rf_wmask(rf_wmask), .busy(busy), .done(done), .err(err)
    );

    logic [SEW-1:0] rf    [32][VLEN];
    logic [SEW-1:0] snap  [32][VLEN];
    logic [SEW-1:0] expv  [32][VLEN];
    logic [SEW-1:0] pk_data [VLEN];
    logic           pk_en = 1'b0;
    int             pk_r  = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    logic [NLANES-1:0] mask_q[$];
    int                beat_q[$];
    logic [NLANES-1:0] em_q[$];
    int                eb_q[$];

    typedef struct {
        logic [5:0] f;
        int vd; int vs1; int vs2; int vl;
        int lat; int wr; bit er;
    } vec_t;
    vec_t tbl [11];

    // Register file: combinational reads
    always_comb begin
        rf_rdata1 = '0;
        rf_rdata2 = '0;
        rf_rdata3 = '0;
        for (int k = 0; k < NLANES; k++) begin
            rf_rdata1[k*SEW +: SEW] = rf[rf_raddr1][int'(rf_rbeat)*NLANES + k];
            rf_rdata2[k*SEW +: SEW] = rf[rf_raddr2][int'(rf_rbeat)*NLANES + k];
            rf_rdata3[k*SEW +: SEW] = rf[rf_raddr3][int'(rf_rbeat)*NLANES + k];
        end
    end

    // Register file: bench preload or masked DUT write
    always @(posedge clk) begin
        if (pk_en) begin
            for (int e = 0; e < VLEN; e++) rf[pk_r][e] <= pk_data[e];
        end else if (rf_we) begin
            for (int k = 0; k < NLANES; k++)
                if (rf_wmask[k]) rf[rf_waddr][int'(rf_wbeat)*NLANES + k] <= rf_wdata[k*SEW +: SEW];
        end
    end

    // Event monitor
    always @(posedge clk) begin
        if (rf_we) begin
            wr_cnt++;
            mask_q.push_back(rf_wmask);
            beat_q.push_back(int'(rf_wbeat));
        end
        if (!rst && in_valid && in_ready) acc_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input int r);
        pk_r  = r;
        pk_en = 1'b1;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("ready_wait", int'(in_ready), 1);
    endtask

    // Reference model: element-level semantics applied to a snapshot of the RF.
    task automatic model(input logic [5:0] f, input int vd, input int vs1, input int vs2,
                         input int vl, output int lat, output int wr, output bit er);
        int vlc, nb;
        logic [SEW-1:0] s, p;
        logic [NLANES-1:0] m;
        for (int r = 0; r < 32; r++)
            for (int e = 0; e < VLEN; e++) begin
                snap[r][e] = rf[r][e];
                expv[r][e] = rf[r][e];
            end
        em_q.delete();
        eb_q.delete();
        vlc = (vl > VLEN) ? VLEN : vl;
        nb  = (vlc + NLANES - 1) / NLANES;
        er  = !(f == F_ADD || f == F_MUL || f == F_MACC || f == F_DOT);
        if (er || vlc == 0) begin
            lat = 1;
            wr  = 0;
        end else if (f == F_DOT) begin
            s = '0;
            for (int e = 0; e < vlc; e++) begin
                p = snap[vs1][e] * snap[vs2][e];
                s = s + p;
            end
            expv[vd][0] = s;
            em_q.push_back(NLANES'(1));
            eb_q.push_back(0);
            lat = nb + 2;
            wr  = 1;
        end else begin
            for (int e = 0; e < vlc; e++) begin
                p = snap[vs1][e] * snap[vs2][e];
                if (f == F_ADD)      expv[vd][e] = snap[vs1][e] + snap[vs2][e];
                else if (f == F_MUL) expv[vd][e] = p;
                else                 expv[vd][e] = snap[vd][e] + p;
            end
            for (int b = 0; b < nb; b++) begin
                m = '0;
                for (int k = 0; k < NLANES; k++) m[k] = (b*NLANES + k < vlc);
                em_q.push_back(m);
                eb_q.push_back(b);
            end
            lat = nb + 1;
            wr  = nb;
        end
    endtask

    task automatic compare_rf(input string name);
        int nbad = 0;
        for (int r = 0; r < 32; r++)
            for (int e = 0; e < VLEN; e++)
                if (rf[r][e] !== expv[r][e]) begin
                    if (nbad == 0)
                        $display("  first diff v%0d[%0d]: got 0x%0h want 0x%0h", r, e, rf[r][e], expv[r][e]);
                    nbad++;
                end
        check(name, nbad, 0);
    endtask

    task automatic run_op(input logic [5:0] f, input int vd, input int vs1, input int vs2,
                          input int vl, input bit use_tab, input int tlat, input int twr, input bit ter);
        int mlat, mwr, lat, nbad;
        bit merr, got_done, got_err;
        model(f, vd, vs1, vs2, vl, mlat, mwr, merr);
        if (use_tab) begin
            mlat = tlat;
            mwr  = twr;
            merr = ter;
        end
        wait_idle();
        wr_cnt = 0;
        mask_q.delete();
        beat_q.delete();
        in_valid  = 1'b1;
        in_funct6 = f;
        in_vd     = 5'(vd);
        in_vs1    = 5'(vs1);
        in_vs2    = 5'(vs2);
        in_vl     = VLW'(vl);
        lat = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        while (!got_done && lat < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
            end
        end
        check("done_seen", int'(got_done), 1);
        check("latency", lat, mlat);
        check("err", int'(got_err), int'(merr));
        @(negedge clk);
        check("write_count", wr_cnt, mwr);
        nbad = (mask_q.size() != em_q.size()) ? 1 : 0;
        for (int i = 0; i < mask_q.size() && i < em_q.size(); i++)
            if (mask_q[i] !== em_q[i] || beat_q[i] != eb_q[i]) nbad++;
        check("wmask_seq", nbad, 0);
        compare_rf("rf_contents");
    endtask

    initial begin
        int mlat, mwr, nbad;
        bit merr;
        logic [SEW-1:0] v1s [VLEN];
        logic [SEW-1:0] v2s [VLEN];
        logic [5:0] fsel [5];

        tbl[0]  = '{F_ADD,  3,  1,  2, 32, 3, 2, 1'b0};
        tbl[1]  = '{F_MUL,  4,  1,  3, 20, 3, 2, 1'b0};
        tbl[2]  = '{F_MACC, 8,  6,  7, 32, 3, 2, 1'b0};
        tbl[3]  = '{F_DOT,  5,  1,  1, 32, 4, 1, 1'b0};
        tbl[4]  = '{F_MUL,  11, 9, 10, 32, 3, 2, 1'b0};
        tbl[5]  = '{F_ADD,  12, 1,  2,  0, 1, 0, 1'b0};
        tbl[6]  = '{F_ADD,  13, 1,  2, 40, 3, 2, 1'b0};
        tbl[7]  = '{F_BAD,  14, 1,  2, 32, 1, 0, 1'b1};
        tbl[8]  = '{F_ADD,  15, 1,  1, 16, 2, 1, 1'b0};
        tbl[9]  = '{F_MACC, 1,  1,  2, 17, 3, 2, 1'b0};
        tbl[10] = '{F_DOT,  16, 2,  2,  1, 3, 1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_funct6 = '0; in_vd = '0; in_vs1 = '0; in_vs2 = '0; in_vl = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_we", int'(rf_we), 0);
        check("rst_wmask", int'(rf_wmask), 0);
        check("rst_wdata_or", int'(|rf_wdata), 0);

        for (int r = 0; r < 32; r++) begin
            for (int e = 0; e < VLEN; e++) begin
                case (r)
                    1:       pk_data[e] = SEW'(e + 1);
                    2:       pk_data[e] = SEW'(e + 3);
                    4:       pk_data[e] = 32'h0000DEAD;
                    5:       pk_data[e] = 32'h00005555;
                    6, 7:    pk_data[e] = 32'd2;
                    8:       pk_data[e] = 32'd7;
                    9:       pk_data[e] = 32'hFFFFFFFF;
                    10:      pk_data[e] = 32'd2;
                    default: pk_data[e] = $urandom;
                endcase
            end
            poke(r);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_op(tbl[i].f, tbl[i].vd, tbl[i].vs1, tbl[i].vs2, tbl[i].vl, 1'b1,
                   tbl[i].lat, tbl[i].wr, tbl[i].er);

        check("v3_e0", int'(rf[3][0]), 4);
        check("v3_e31", int'(rf[3][31]), 66);
        check("v4_e19", int'(rf[4][19]), 840);
        check("v4_e20_tail", int'(rf[4][20]), 32'h0000DEAD);
        check("v8_macc", int'(rf[8][17]), 11);
        check("v5_dot", int'(rf[5][0]), 11440);
        check("v5_e1_kept", int'(rf[5][1]), 32'h00005555);
        check("v11_wrap", int'(rf[11][5]), 32'hFFFFFFFE);

        // in_valid held across two ops: exactly one accept per completed op
        wait_idle();
        model(F_ADD, 19, 2, 2, 16, mlat, mwr, merr);
        acc_cnt  = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        in_valid = 1'b1;
        in_funct6 = F_ADD; in_vd = 5'd19; in_vs1 = 5'd2; in_vs2 = 5'd2; in_vl = VLW'(16);
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check("held_accepts", acc_cnt, 2);
        check("held_dones", done_cnt, 2);
        check("held_writes", wr_cnt, 2);
        check("held_ready_after", int'(in_ready), 1);
        compare_rf("held_rf");

        // reset after the first write beat of a full-length VADD
        for (int e = 0; e < VLEN; e++) pk_data[e] = 32'h00001234;
        poke(17);
        for (int e = 0; e < VLEN; e++) begin
            v1s[e] = rf[1][e];
            v2s[e] = rf[2][e];
        end
        wait_idle();
        wr_cnt = 0;
        in_valid = 1'b1;
        in_funct6 = F_ADD; in_vd = 5'd17; in_vs1 = 5'd1; in_vs2 = 5'd2; in_vl = VLW'(32);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_seq_first_we", int'(rf_we), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_seq_ready", int'(in_ready), 1);
        check("rst_seq_we_off", int'(rf_we), 0);
        check("rst_seq_busy", int'(busy), 0);
        @(negedge clk);
        check("rst_seq_writes", wr_cnt, 1);
        nbad = 0;
        for (int e = 0; e < VLEN; e++) begin
            if (e < NLANES) begin
                if (rf[17][e] !== v1s[e] + v2s[e]) nbad++;
            end else begin
                if (rf[17][e] !== 32'h00001234) nbad++;
            end
        end
        check("rst_seq_rf", nbad, 0);
        run_op(F_ADD, 18, 2, 2, 16, 1'b0, 0, 0, 1'b0);

        // randomized ops against the reference model
        fsel[0] = F_ADD; fsel[1] = F_MUL; fsel[2] = F_MACC; fsel[3] = F_DOT;
        for (int it = 0; it < 40; it++) begin
            for (int e = 0; e < VLEN; e++) pk_data[e] = $urandom;
            poke(20 + $urandom_range(0, 7));
            fsel[4] = 6'($urandom);
            run_op(fsel[$urandom_range(0, 4)], 20 + $urandom_range(0, 7),
                   20 + $urandom_range(0, 7), 20 + $urandom_range(0, 7),
                   $urandom_range(0, 40), 1'b0, 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
